// File: rtl/ifetch_pkg.sv
// Shared constants, entry type and width helper for the instruction-fetch stage.
package ifetch_pkg;

  localparam int unsigned IfetchAddrW   = 14;
  localparam int unsigned IfetchDataW   = 32;
  localparam int unsigned IfetchPcStep  = 4;
  localparam int unsigned IfetchResetPc = 0;

  // Queue entry at the default geometry, as seen by decode.
  typedef struct packed {
    logic [IfetchAddrW-1:0] pc;
    logic [IfetchDataW-1:0] instr;
  } ifetch_entry_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned ifetch_clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/ifetch_rom.sv
// Synchronous single-port instruction ROM, one-cycle read latency.
// The model serves each word's own index as its contents; a preloaded image named by
// ROM_INIT is bound in by the platform memory wrapper rather than by this model.
module ifetch_rom #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 12,
  parameter string       ROM_INIT = ""
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic unused_rom_init;
  assign unused_rom_init = (ROM_INIT != "");

  // Address sampled at the edge, word available for the whole following cycle.
  always_ff @(posedge clk) begin
    rdata_o <= DATA_W'(addr_i);
  end

endmodule

// File: rtl/ifetch_pipe.sv
// Instruction-fetch stage: PC owner, ROM driver and small output queue toward decode.
// Optional build macro: IFETCH_ALIGN_CHK_EN enables the sticky misaligned-redirect fault.
module ifetch_pipe
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IfetchAddrW,
  parameter int unsigned       DATA_W   = IfetchDataW,
  parameter int unsigned       PC_STEP  = IfetchPcStep,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IfetchResetPc),
  parameter int unsigned       QDEPTH   = 2,
  parameter string             ROM_INIT = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              instr_ready_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fault_o
);

  localparam int unsigned StepLog = ifetch_clog2(PC_STEP);
  localparam int unsigned IdxW    = ADDR_W - StepLog;
  localparam int unsigned PtrW    = (QDEPTH <= 1) ? 1 : ifetch_clog2(QDEPTH);
  localparam int unsigned CntW    = ifetch_clog2(QDEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue, pop, push, misaligned;
  logic [CntW:0]     occ;
  logic [DATA_W-1:0] rom_rdata;

  entry_t            fifo_q [QDEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  ifetch_rom #(
    .DATA_W   (DATA_W),
    .IDX_W    (IdxW),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .clk     (clk),
    .addr_i  (issue_addr[ADDR_W-1:StepLog]),
    .rdata_o (rom_rdata)
  );

`ifdef IFETCH_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] StepMask = ADDR_W'(PC_STEP - 1);
  logic fault_q;

  assign misaligned = redirect_i && ((redirect_pc_i & StepMask) != '0);

  // Sticky fault: every redirect rewrites it, so only an aligned redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_i) begin
      fault_q <= misaligned;
    end
  end

  assign fault_o = fault_q;
`else
  assign misaligned = 1'b0;
  assign fault_o    = 1'b0;
`endif

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = fifo_q[rd_ptr_q].instr;
  assign pc_o          = fifo_q[rd_ptr_q].pc;

  // Issue decision, PC advance and queue bookkeeping; redirect overrides everything.
  always_comb begin
    pop        = instr_valid_o & instr_ready_i;
    occ        = {1'b0, count_q} - (CntW + 1)'(pop) + (CntW + 1)'(req_q);
    issue_addr = redirect_i ? redirect_pc_i : fetch_pc_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // A redirect empties the queue, so it never needs a credit.
    if (redirect_i) begin
      issue = !misaligned;
    end else begin
      issue = !fault_o && (occ < (CntW + 1)'(QDEPTH));
    end

    if (issue) begin
      fetch_pc_d = issue_addr + ADDR_W'(PC_STEP);
      req_pc_d   = issue_addr;
    end
    req_d = issue;

    // Data returning for a read issued before the redirect belongs to the old path.
    push = req_q && !redirect_i;

    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // PC, in-flight request tag and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      req_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_q      <= req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: req_pc_q, instr: rom_rdata};
    end
  end

endmodule

// File: tb/tb_ifetch_pipe.sv
// Directed table-driven bench for ifetch_pipe at default parameters.
// The ROM model returns the word index, so the expected instruction is pc >> 2.
module tb_ifetch_pipe;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          instr_ready_i = 1'b1;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] pc_o;
  logic          fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_ready_i (instr_ready_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .fault_o       (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          redir;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] epc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic redir, input logic [AW-1:0] rpc, input logic rdy,
                     input logic ev, input logic [AW-1:0] epc);
    vec_t v;
    v.redir = redir;
    v.rpc   = rpc;
    v.rdy   = rdy;
    v.ev    = ev;
    v.epc   = epc;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [AW-1:0] epc,
                           input logic efault);
    check({tag, " valid"}, DW'(instr_valid_o), DW'(ev));
    if (ev) begin
      check({tag, " pc"}, DW'(pc_o), DW'(epc));
      check({tag, " instr"}, instr_o, DW'(epc >> 2));
    end
    check({tag, " fault"}, DW'(fault_o), DW'(efault));
  endtask

  task automatic drive(input logic redir, input logic [AW-1:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    #1;
  endtask

  initial begin
    // Reset release, sequential stream.
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 1, AW'(4 * k));
    // Ten stalled cycles: head holds, queue fills to two.
    for (int k = 0; k < 10; k++) add(0, 0, 0, 1, 'h10);
    add(0, 0, 1, 1, 'h10);
    add(0, 0, 1, 1, 'h14);
    add(0, 0, 1, 1, 'h18);
    add(0, 0, 1, 1, 'h1C);
    // Redirect while the queue is full with a read in flight.
    add(1, 'h100, 0, 1, 'h20);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 'h100);
    add(0, 0, 1, 1, 'h104);
    // Back-to-back redirects: 0x40 must never appear.
    add(1, 'h40, 1, 1, 'h108);
    add(1, 'h80, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 'h80);
    add(0, 0, 1, 1, 'h84);
    // PC wrap at the top of the address space.
    add(1, 'h3FF8, 1, 1, 'h88);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 'h3FF8);
    add(0, 0, 1, 1, 'h3FFC);
    add(0, 0, 1, 1, 'h0000);
    add(0, 0, 1, 1, 'h0004);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_out("reset", 1'b0, '0, 1'b0);
    check("reset instr", instr_o, '0);
    check("reset pc", DW'(pc_o), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      instr_ready_i = tbl[i].rdy;
      #1;
      check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc, 1'b0);
    end

    // Asynchronous reset mid-stream discards everything immediately.
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("midrst", 1'b0, '0, 1'b0);
    check("midrst instr", instr_o, '0);
    check("midrst pc", DW'(pc_o), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("rel0", 1'b0, '0, 1'b0);
    drive(0, 0, 1);
    check_out("rel1", 1'b0, '0, 1'b0);
    drive(0, 0, 1);
    check_out("rel2", 1'b1, 'h0, 1'b0);
    drive(0, 0, 1);
    check_out("rel3", 1'b1, 'h4, 1'b0);

`ifdef IFETCH_ALIGN_CHK_EN
    // Misaligned redirect faults and blocks issue until an aligned redirect.
    drive(1, 'h102, 1);
    check_out("mis0", 1'b1, 'h8, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1);
      check_out($sformatf("mis%0d", k + 1), 1'b0, '0, 1'b1);
    end
    drive(1, 'h200, 1);
    check_out("fix0", 1'b0, '0, 1'b1);
    drive(0, 0, 1);
    check_out("fix1", 1'b0, '0, 1'b0);
    drive(0, 0, 1);
    check_out("fix2", 1'b1, 'h200, 1'b0);
    drive(0, 0, 1);
    check_out("fix3", 1'b1, 'h204, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_pipe.md
# ifetch_pipe

Parametrised instruction-fetch stage: owns the program counter, drives a synchronous instruction ROM, and hands {instruction, PC} pairs to decode over a valid/ready handshake. It is the successor to the single-register fetch stage. It adds:
- back-pressure via a small output queue;
- redirect with flush of in-flight fetches;
- a configurable reset vector and word geometry.

It sits between the PC-redirect logic (branch/jump resolution) and the decode stage.

## Interface
Parameters:
- ADDR_W, 14, PC width in bytes
- DATA_W, 32, instruction width
- PC_STEP, 4, sequential PC increment (bytes per instruction)
- RESET_PC, 0, PC fetched first after reset
- QDEPTH, 2, output queue entries (minimum 2)
- ROM_INIT, "", memory init file passed to the ROM

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- redirect_i  in  1  load new PC, flush in-flight and queued fetches
- redirect_pc_i  in  ADDR_W  redirect target
- instr_ready_i  in  1  decode accepts head entry
- instr_valid_o  out  1  head entry valid
- instr_o  out  DATA_W  head instruction
- pc_o  out  ADDR_W  byte address of instr_o
- fault_o  out  1  misaligned redirect seen (IFETCH_ALIGN_CHK_EN only; tied 0 otherwise)

## Operation
- State:
  - fetch_pc: next address to issue.
  - req_q: ROM read in flight, with its PC tag.
  - FIFO of QDEPTH {instr, pc} entries with count.
- Issue: a read is issued in a cycle when (count − pop) + req_q < QDEPTH, where pop = instr_valid_o & instr_ready_i.
  - ROM address = redirect_i ? redirect_pc_i : fetch_pc.
  - On issue: fetch_pc ← address + PC_STEP (modulo 2^ADDR_W, wraps silently).
- Return: when req_q is set, ROM data plus tag are pushed into the FIFO at the end of that cycle.
- Output: FIFO head drives instr_o/pc_o. instr_valid_o = (count != 0). Head is stable while valid & !ready.
- Redirect (highest priority):
  - Clears FIFO count and cancels req_q in the same edge; any ROM data returning for the old path is discarded.
  - Issues redirect_pc_i in the same cycle (bypassing the credit check, since the queue is empty afterwards).
  - A pop in the redirect cycle is honoured (decode keeps that instruction); everything else is dropped.
- Back-to-back redirects: the last one wins; each cancels the previous one's in-flight read.
- Reset: async, while rst_n=0.
  - fetch_pc=RESET_PC, req_q=0, count=0.
  - instr_valid_o=0, instr_o=0, pc_o=0, fault_o=0.
  - Reset mid-operation discards all entries.

## Timing
- ROM read latency: 1 cycle (address sampled at posedge, data valid in the next cycle).
- Redirect asserted in cycle N → target instruction valid at cycle N+2.
- First reset release: RESET_PC valid 2 cycles after the first active edge.
- With instr_ready_i held at 1: one instruction per cycle sustained, PC stride PC_STEP.
- Stall (ready=0): at most QDEPTH entries are held, with no overrun and no lost fetch.
- After ready returns: issue resumes the same cycle; throughput 1/cycle is restored with no bubble when QDEPTH ≥ 2.

## Configuration
- IFETCH_ALIGN_CHK_EN defined:
  - A redirect whose target has log2(PC_STEP) low bits nonzero sets fault_o (sticky) and blocks all further issue.
  - Cleared only by reset or by a subsequent aligned redirect, which also resumes fetch.
- Undefined: low bits are ignored (the ROM word index uses bits [ADDR_W-1:log2(PC_STEP)]); fault_o is constant 0.

## Structure
- Package ifetch_pkg:
  - default widths, PC_STEP and RESET_PC constants;
  - packed entry typedef {pc, instr};
  - clog2 helper for the FIFO pointer width.
- Sub-module ifetch_rom: synchronous single-port ROM, parameters DATA_W, depth 2^(ADDR_W−log2 PC_STEP), ROM_INIT, 1-cycle read.
- The FIFO stays inline; it is small and needs the custom flush.

## Test plan
- Reset release, ready=1, ROM[i]=i → pc_o 0,4,8,… with instr_o 0,1,2,…, first valid 2 cycles after reset, one per cycle, no gaps.
- Hold ready=0 for 10 cycles from steady stream → valid stays 1, head pc unchanged, no more than QDEPTH fetched; release → next pcs consecutive, none skipped or duplicated.
- Redirect to 0x100 while queue is full and a read is in flight → old entries gone next cycle, pc_o=0x100 valid exactly 2 cycles later, then 0x104.
- Redirect to 0x40 then 0x80 on consecutive cycles → 0x40 never appears; 0x80 valid 2 cycles after the second redirect.
- PC at 2^ADDR_W−4 with ready=1 → next pc_o wraps to 0.
- IFETCH_ALIGN_CHK_EN: redirect to 0x102 → fault_o=1, valid stays 0; then redirect to 0x200 → fault_o=0, 0x200 valid 2 cycles later.
